// File: rtl/lcd_pkg.sv
// lcd_pkg: frame-buffer geometry shared by the VRAM writer and LCD scan-out, plus fill FSM encoding
package lcd_pkg;
  function automatic int bit_fit(input int v);
    int b;
    b = 1;
    for (int i = 1; i < 31; i++) if ((v >> i) != 0) b = i + 1;
    return b;
  endfunction
  localparam int HPXL = 800;
  localparam int VPXL = 480;
  localparam int ABW = bit_fit(HPXL * VPXL - 1);
  localparam int HBW = bit_fit(HPXL - 1);
  localparam int VBW = bit_fit(VPXL - 1);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} fill_state_e;
endpackage

// File: rtl/vram_fill_clip.sv
// vram_fill_clip: clips a rectangle to the screen, flags empty ones and forms the top-left VRAM address
module vram_fill_clip
  import lcd_pkg::*;
(
  input  logic [HBW-1:0] x_i,
  input  logic [VBW-1:0] y_i,
  input  logic [HBW-1:0] w_i,
  input  logic [VBW-1:0] h_i,
  output logic [HBW-1:0] wc_o,
  output logic [VBW-1:0] hc_o,
  output logic           empty_o,
  output logic [ABW-1:0] base_o
);
  logic [HBW:0] rem_x;
  logic [VBW:0] rem_y;
  logic [ABW:0] y_w;
  logic [ABW:0] sum;
  // Room left to the screen edge goes negative (top bit set) when the origin is off-screen;
  // y*800 is built as y*512 + y*256 + y*32
  always_comb begin
    rem_x = (HBW+1)'(HPXL) - {1'b0, x_i};
    rem_y = (VBW+1)'(VPXL) - {1'b0, y_i};
    y_w = (ABW+1)'(y_i);
    sum = (y_w << 9) + (y_w << 8) + (y_w << 5) + (ABW+1)'(x_i);
    wc_o = ({1'b0, w_i} < rem_x) ? w_i : rem_x[HBW-1:0];
    hc_o = ({1'b0, h_i} < rem_y) ? h_i : rem_y[VBW-1:0];
    empty_o = rem_x[HBW] || rem_x == '0 || rem_y[VBW] || rem_y == '0 || w_i == '0 || h_i == '0 || sum[ABW];
    base_o = sum[ABW-1:0];
  end
endmodule

// File: rtl/vram_fill.sv
// vram_fill: solid-colour rectangle fill engine, one VRAM pixel write per unstalled cycle
module vram_fill
  import lcd_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  input  logic           iSTART,
  input  logic [HBW-1:0] iX,
  input  logic [VBW-1:0] iY,
  input  logic [HBW-1:0] iW,
  input  logic [VBW-1:0] iH,
  input  logic [23:0]    iCOLOR,
  input  logic           iSTALL,
  output logic           oBUSY,
  output logic           oDONE,
  output logic           oWE,
  output logic [ABW-1:0] oWADDR,
  output logic [23:0]    oWDATA
);
  fill_state_e    state_q;
  logic [HBW-1:0] x_q, w_q, wc_q, col_q, wc_d;
  logic [VBW-1:0] y_q, h_q, hc_q, row_q, hc_d;
  logic [23:0]    color_q, wdata_q;
  logic [ABW-1:0] addr_q, waddr_q, base_d;
  logic           busy_q, done_q, we_q, empty_d, row_end, last_pix;
  vram_fill_clip u_clip (
    .x_i(x_q), .y_i(y_q), .w_i(w_q), .h_i(h_q),
    .wc_o(wc_d), .hc_o(hc_d), .empty_o(empty_d), .base_o(base_d)
  );
  assign row_end = col_q == wc_q - HBW'(1);
  assign last_pix = row_end && row_q == hc_q - VBW'(1);
  assign oBUSY = busy_q;
  assign oDONE = done_q;
  assign oWE = we_q;
  assign oWADDR = waddr_q;
  assign oWDATA = wdata_q;
  // Command FSM with raster counters; outputs reflect the state the edge was taken from
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      {x_q, w_q, wc_q, col_q} <= '0;
      {y_q, h_q, hc_q, row_q} <= '0;
      {color_q, wdata_q, addr_q, waddr_q} <= '0;
      {busy_q, done_q, we_q} <= '0;
    end else begin
      busy_q <= state_q != S_IDLE;
      done_q <= state_q == S_DONE;
      we_q <= state_q == S_FILL && !iSTALL;
      case (state_q)
        S_IDLE: if (iSTART) begin
          {x_q, y_q, w_q, h_q, color_q} <= {iX, iY, iW, iH, iCOLOR};
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          {wc_q, hc_q, addr_q} <= {wc_d, hc_d, base_d};
          {col_q, row_q} <= '0;
          state_q <= empty_d ? S_DONE : S_FILL;
        end
        S_FILL: begin
          waddr_q <= addr_q;
          wdata_q <= color_q;
          if (!iSTALL) begin
            if (last_pix) state_q <= S_DONE;
            else if (row_end) begin
              col_q <= '0;
              row_q <= row_q + VBW'(1);
              addr_q <= addr_q + ABW'(HPXL + 1) - ABW'(wc_q);
            end else begin
              col_q <= col_q + HBW'(1);
              addr_q <= addr_q + ABW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/vram_fill.md
# vram_fill

Rectangle-fill engine that writes a solid 24-bit colour into the 800x480 frame buffer through the VRAM write port. It is the writer side of the VRAM, while the LCD scan-out controller reads the same buffer at linear address `y*800 + x`. It accepts one command at a time from the CPU-side register block, clips the rectangle to the screen, and emits one pixel write per unstalled cycle.

## Interface
Parameters:
- `HPXL`, 800: horizontal pixels.
- `VPXL`, 480: vertical lines.
- `ABW`, 19: VRAM address width, `bit_fit(HPXL*VPXL-1)`.
- `HBW`, 10: x/width field width, `bit_fit(HPXL-1)`.
- `VBW`, 9: y/height field width, `bit_fit(VPXL-1)`.

Ports:
- `clk` input 1: single clock, all logic.
- `rst_` input 1: asynchronous, active-low reset.
- `iSTART` input 1: command strobe; sampled only in IDLE.
- `iX` input HBW: left column.
- `iY` input VBW: top row.
- `iW` input HBW: width in pixels.
- `iH` input VBW: height in lines.
- `iCOLOR` input 24: fill colour, {R,G,B}.
- `iSTALL` input 1: VRAM port busy; hold the current write.
- `oBUSY` output 1: command in progress.
- `oDONE` output 1: one-cycle completion pulse.
- `oWE` output 1: VRAM write enable.
- `oWADDR` output ABW: VRAM write address.
- `oWDATA` output 24: VRAM write data.

## Operation
- FSM states: IDLE, SETUP, FILL, DONE.
- IDLE:
  - `oBUSY=0`.
  - When `iSTART=1`, latch X, Y, W, H and COLOR, then go to SETUP.
- SETUP (one cycle):
  - Clip the rectangle: `wc = min(W, HPXL-X)` and `hc = min(H, VPXL-Y)`.
  - If `X>=HPXL`, `Y>=VPXL`, `W==0` or `H==0`, the rectangle is empty and the next state is DONE.
  - Otherwise load `addr = Y*HPXL + X`, computed as `(Y<<9)+(Y<<8)+(Y<<5)+X` with no multiplier. Zero the column and row counters, then go to FILL.
- FILL: each cycle with `iSTALL=0`:
  - Assert `oWE=1`, `oWADDR=addr`, `oWDATA=colour`.
  - If `col < wc-1`: `col++`, `addr++`.
  - Else: `col=0`, `row++`, `addr += HPXL-wc+1`.
  - The last pixel is `col==wc-1 && row==hc-1`; go to DONE after writing it.
- FILL with `iSTALL=1`:
  - Drive `oWE=0`.
  - Hold `addr`, `col` and `row`.
  - The pending pixel is issued on the first unstalled cycle.
- DONE: `oDONE=1` for one cycle, then go to IDLE.
- `iSTART` is ignored in SETUP, FILL and DONE; it is not queued.
- Width rules:
  - `wc` and `hc` are HBW and VBW bits wide.
  - Intermediate sums use ABW+1 bits.
  - `addr` never exceeds `HPXL*VPXL-1`, because the clipping guarantees it.
- Pixel order is row-major, left to right, then top to bottom. Addresses strictly increase within a command.

## Timing
- All outputs are registered.
- Reset values:
  - `oBUSY=0`, `oDONE=0`, `oWE=0`.
  - `oWADDR=0`, `oWDATA=0`.
  - State is IDLE.
- Command cycle, with `iSTART` sampled at edge T and N = `wc*hc` pixels:
  - `oBUSY` goes high at T+1 (SETUP).
  - The first `oWE` is at T+2.
  - With no stalls, the last `oWE` is at T+1+N.
  - `oDONE` is high at T+2+N; `oBUSY` stays high through the same cycle.
  - A new `iSTART` is accepted at T+3+N.
- Empty rectangle: `oDONE` at T+2 with no `oWE`.
- Each stalled FILL cycle delays completion by one cycle.
- `oWE` never asserts outside FILL.
- Reset asserted mid-command:
  - All outputs clear immediately (asynchronous) and no further writes occur.
  - After `rst_` is released, the block is in IDLE and accepts a command on the next edge.

## Structure
- Shared package `lcd_pkg`, also used by the LCD scan-out controller:
  - constants HPXL, VPXL, ABW, HBW, VBW;
  - the `bit_fit` function;
  - the FSM state encoding for this block.
- Sub-module `vram_fill_clip`: the combinational clip/empty check plus the base-address shift-add, instantiated once in SETUP.
- Counters, address register and FSM live in the top module.

## Test plan
- Full screen: (0,0,800,480,0xFF0000) -> 384000 writes, addresses 0..383999 consecutive, data 0xFF0000, `oDONE` at T+384002.
- Small rectangle: (10,5,3,2,0x00FF00) -> writes in order at 4010, 4011, 4012, 4810, 4811, 4812, then `oDONE` at T+8.
- Clipping: (798,479,5,5,0x0000FF) -> exactly two writes, at 383998 and 383999, then `oDONE`.
- Empty rectangles: W=0, then X=800 -> no `oWE`, `oDONE` at T+2 for each.
- Stall: (0,0,4,1) with `iSTALL` high for 3 cycles after the 2nd write -> `oWE` low and `oWADDR` held at 2 while stalled; 4 writes total; `oDONE` 3 cycles later than unstalled.
- Reset and busy handling:
  - Pulse `rst_` low mid-fill -> outputs are 0 immediately and no writes follow.
  - `iSTART` issued while busy is ignored.
  - A fresh command after reset runs normally.
